gumnut_alu: RTL and testbench

- Datapath ALU for the Gumnut 8-bit soft core.
- Decodes the 18-bit instruction register directly and combinationally produces the 8-bit result for these instruction classes:
  - register-form arithmetic/logic
  - immediate-form arithmetic/logic
  - shift/rotate
  - memory address generation
- Holds the carry (C) and zero (Z) condition-code flags in registers clocked by the core clock. addc and subc consume the stored C.

---
 rtl/gumnut_alu.sv | 146 ++++++++++++++
 tb/tb_gumnut_alu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gumnut_alu.sv
// Gumnut 8-bit ALU: decodes IR combinationally, holds the C/Z flags in registers.
// Optional macro ALU_SHIFT_RESULT_EN adds the ALU_shift_result debug/writeback port.
module gumnut_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  GPR_rs,
    input  logic [7:0]  GPR_r2,
    input  logic [17:0] IR,
`ifdef ALU_SHIFT_RESULT_EN
    output logic [7:0]  ALU_shift_result,
`endif
    output logic [7:0]  ALU_result,
    output logic        cc_C,
    output logic        cc_Z
);

    logic        isImm;
    logic        isMem;
    logic        isShift;
    logic        isReg;

    logic [2:0]  shCount;
    logic [1:0]  shFn;
    logic [15:0] shWide;
    logic [7:0]  shResult;
    logic        shCarry;

    logic [2:0]  aluFn;
    logic [7:0]  aluB;
    logic [8:0]  aluWide;

    logic [7:0]  memAddr;
    logic [7:0]  result;
    logic        carryNext;
    logic        flagUpdate;

    logic        c_q;
    logic        c_d;
    logic        z_q;
    logic        z_d;

    logic        unusedIr;

    assign isImm   = ~IR[17];
    assign isMem   = (IR[17:16] == 2'b10);
    assign isShift = (IR[17:15] == 3'b110);
    assign isReg   = (IR[17:14] == 4'b1110);

    assign shCount = IR[7:5];
    assign shFn    = IR[1:0];

    // Shifts run in a 16-bit window so the last bit shifted out lands at a fixed index.
    always_comb begin
        shWide   = 16'h0000;
        shResult = 8'h00;
        shCarry  = 1'b0;
        case (shFn)
            2'b00: begin
                shWide   = {8'h00, GPR_rs} << shCount;
                shResult = shWide[7:0];
                shCarry  = shWide[8];
            end
            2'b01: begin
                shWide   = {GPR_rs, 8'h00} >> shCount;
                shResult = shWide[15:8];
                shCarry  = shWide[7];
            end
            2'b10: begin
                shWide   = {GPR_rs, GPR_rs} << shCount;
                shResult = shWide[15:8];
            end
            default: begin
                shWide   = {GPR_rs, GPR_rs} >> shCount;
                shResult = shWide[7:0];
            end
        endcase
    end

    assign aluFn = isImm ? IR[16:14] : IR[2:0];
    assign aluB  = isImm ? IR[7:0] : GPR_r2;

    // Bit 8 of a difference is the borrow, since the 9-bit result goes negative when A < B(+C).
    always_comb begin
        aluWide = 9'h000;
        case (aluFn)
            3'b000:  aluWide = {1'b0, GPR_rs} + {1'b0, aluB};
            3'b001:  aluWide = {1'b0, GPR_rs} + {1'b0, aluB} + {8'h00, c_q};
            3'b010:  aluWide = {1'b0, GPR_rs} - {1'b0, aluB};
            3'b011:  aluWide = {1'b0, GPR_rs} - {1'b0, aluB} - {8'h00, c_q};
            3'b100:  aluWide = {1'b0, GPR_rs & aluB};
            3'b101:  aluWide = {1'b0, GPR_rs | aluB};
            3'b110:  aluWide = {1'b0, GPR_rs ^ aluB};
            default: aluWide = {1'b0, GPR_rs & ~aluB};
        endcase
    end

    assign memAddr = GPR_rs + IR[7:0];

    always_comb begin
        result     = 8'h00;
        carryNext  = 1'b0;
        flagUpdate = 1'b0;
        if (isImm || isReg) begin
            result     = aluWide[7:0];
            carryNext  = aluWide[8];
            flagUpdate = 1'b1;
        end else if (isMem) begin
            result = memAddr;
        end else if (isShift) begin
            result     = shResult;
            carryNext  = shCarry;
            flagUpdate = 1'b1;
        end
    end

    always_comb begin
        c_d = c_q;
        z_d = z_q;
        if (flagUpdate) begin
            c_d = carryNext;
            z_d = (result == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    assign ALU_result = result;
    assign cc_C       = c_q;
    assign cc_Z       = z_q;

`ifdef ALU_SHIFT_RESULT_EN
    assign ALU_shift_result = shResult;
`endif

    // Displacement/unused opcode bits carry no meaning for the ALU itself.
    assign unusedIr = ^{IR[13:8], IR[4:3]};

endmodule

// File: tb/tb_gumnut_alu.sv
// Self-checking bench for gumnut_alu: directed test-plan steps, then random IRs
// checked against an arithmetic reference model of the instruction set.
module tb_gumnut_alu;

    logic        clk;
    logic        rst_n;
    logic [7:0]  GPR_rs;
    logic [7:0]  GPR_r2;
    logic [17:0] IR;
    logic [7:0]  ALU_result;
    logic        cc_C;
    logic        cc_Z;
`ifdef ALU_SHIFT_RESULT_EN
    logic [7:0]  ALU_shift_result;
`endif

    int testsRun  = 0;
    int failCount = 0;
    bit modelC    = 1'b0;
    bit modelZ    = 1'b0;

    gumnut_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .GPR_rs    (GPR_rs),
        .GPR_r2    (GPR_r2),
        .IR        (IR),
`ifdef ALU_SHIFT_RESULT_EN
        .ALU_shift_result (ALU_shift_result),
`endif
        .ALU_result(ALU_result),
        .cc_C      (cc_C),
        .cc_Z      (cc_Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void shiftModel(input int a, input int n, input int sfn,
                                       output int res, output int cout);
        res  = a;
        cout = 0;
        case (sfn)
            0: begin
                res  = (a << n) & 255;
                cout = (n == 0) ? 0 : ((a >> (8 - n)) & 1);
            end
            1: begin
                res  = a >> n;
                cout = (n == 0) ? 0 : ((a >> (n - 1)) & 1);
            end
            2: res = ((a << n) | (a >> (8 - n))) & 255;
            default: res = ((a >> n) | (a << (8 - n))) & 255;
        endcase
    endfunction

    function automatic void aluModel(input logic [17:0] ir, input int a, input int r2,
                                     input int cin, output int res, output int cout,
                                     output bit upd);
        int fn;
        int b;
        int s;
        res  = 0;
        cout = 0;
        upd  = 1'b0;
        fn   = -1;
        b    = 0;
        if (ir[17] == 1'b0) begin
            fn = int'(ir[16:14]);
            b  = int'(ir[7:0]);
        end else if (ir[17:16] == 2'b10) begin
            res = (a + int'(ir[7:0])) % 256;
        end else if (ir[17:15] == 3'b110) begin
            shiftModel(a, int'(ir[7:5]), int'(ir[1:0]), res, cout);
            upd = 1'b1;
        end else if (ir[17:14] == 4'b1110) begin
            fn = int'(ir[2:0]);
            b  = r2;
        end
        if (fn >= 0) begin
            upd = 1'b1;
            case (fn)
                0: begin s = a + b;       res = s % 256;         cout = (s > 255) ? 1 : 0; end
                1: begin s = a + b + cin; res = s % 256;         cout = (s > 255) ? 1 : 0; end
                2: begin s = a - b;       res = (s + 512) % 256; cout = (s < 0) ? 1 : 0;   end
                3: begin s = a - b - cin; res = (s + 512) % 256; cout = (s < 0) ? 1 : 0;   end
                4: res = a & b;
                5: res = a | b;
                6: res = a ^ b;
                default: res = a & (~b & 255);
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one instruction, checks the combinational result, then checks the flags one edge later.
    task automatic applyStimulus(input logic [17:0] ir, input logic [7:0] rs,
                                 input logic [7:0] r2, input int planResult, input int planC);
        int expRes;
        int expC;
        bit upd;
`ifdef ALU_SHIFT_RESULT_EN
        int shRes;
        int shC;
`endif
        IR     = ir;
        GPR_rs = rs;
        GPR_r2 = r2;
        #1;
        aluModel(ir, int'(rs), int'(r2), int'(modelC), expRes, expC, upd);
        checkOutput("result", ALU_result, expRes[7:0]);
        if (planResult >= 0) checkOutput("planResult", ALU_result, planResult[7:0]);
`ifdef ALU_SHIFT_RESULT_EN
        shiftModel(int'(rs), int'(ir[7:5]), int'(ir[1:0]), shRes, shC);
        checkOutput("shiftResult", ALU_shift_result, shRes[7:0]);
`endif
        @(posedge clk);
        #1;
        if (upd) begin
            modelC = expC[0];
            modelZ = (expRes == 0);
        end
        checkOutput("flagC", {7'b0, cc_C}, {7'b0, modelC});
        checkOutput("flagZ", {7'b0, cc_Z}, {7'b0, modelZ});
        if (planC >= 0) checkOutput("planC", {7'b0, cc_C}, planC[7:0]);
    endtask

    initial begin
        logic [17:0] rir;
        rst_n  = 1'b0;
        IR     = '0;
        GPR_rs = '0;
        GPR_r2 = '0;
        #1;
        checkOutput("resetC", {7'b0, cc_C}, 8'h00);
        checkOutput("resetZ", {7'b0, cc_Z}, 8'h00);
        #11 rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(18'b111000000000000000, 8'd5,   8'd5,   10, 0);
        applyStimulus(18'b111000000000000010, 8'd5,   8'd5,    0, 0);
        checkOutput("subZ", {7'b0, cc_Z}, 8'h01);
        applyStimulus(18'b111000000000000000, 8'd200, 8'd100, 44, 1);
        applyStimulus(18'b111000000000000001, 8'd3,   8'd2,    6, 0);
        applyStimulus(18'b111000000000000000, 8'd200, 8'd100, 44, 1);
        applyStimulus(18'b111000000000000011, 8'd4,   8'd1,    2, 0);
        applyStimulus(18'b000000000000001010, 8'd125, 8'd0,  135, -1);
        applyStimulus(18'b001000000000001010, 8'd125, 8'd0,  115, -1);
        applyStimulus(18'b111000000000000100, 8'hF0,  8'h3C, 'h30, 0);
        applyStimulus(18'b111000000000000111, 8'hF0,  8'h3C, 'hC0, 0);
        applyStimulus({3'b110, 7'b0, 3'b001, 3'b000, 2'b00}, 8'h81, 8'h00, 'h02, 1);

        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetC", {7'b0, cc_C}, 8'h00);
        checkOutput("asyncResetZ", {7'b0, cc_Z}, 8'h00);
        modelC = 1'b0;
        modelZ = 1'b0;
        #2 rst_n = 1'b1;

        applyStimulus({3'b110, 7'b0, 3'b001, 3'b000, 2'b11}, 8'h01, 8'h00, 'h80, 0);
        applyStimulus({3'b110, 7'b0, 3'b001, 3'b000, 2'b00}, 8'h81, 8'h00, 'h02, 1);
        applyStimulus({2'b10, 8'h00, 8'h20}, 8'hF0, 8'h00, 'h10, 1);
        applyStimulus({3'b110, 7'b0, 3'b000, 3'b000, 2'b00}, 8'h81, 8'h00, 'h81, 0);

        applyStimulus(18'b111000000000000000, 8'hFF, 8'hFF, 'hFE, 1);
        applyStimulus(18'b111000000000000001, 8'hFF, 8'h00, -1, -1);
        applyStimulus(18'b111000000000000001, 8'hFF, 8'h00, -1, -1);
        applyStimulus(18'b111000000000000011, 8'h00, 8'hFF, -1, 1);
        applyStimulus({4'b1111, 14'h0}, 8'h55, 8'hAA, 0, -1);

        for (int i = 0; i < 300; i++) begin
            rir = 18'($urandom);
            applyStimulus(rir, 8'($urandom), 8'($urandom), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
